// File: rtl/la_spram_ctrl_if.sv
// Request/response bundle between a client and la_spram_ctrl.
// master = requester side, slave = controller side.
interface la_spram_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 10
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wmask;
    logic [DW-1:0] req_din;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_dout;

    modport master (
        output req_valid, req_we, req_addr, req_wmask, req_din, rsp_ready,
        input  req_ready, rsp_valid, rsp_dout
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wmask, req_din, rsp_ready,
        output req_ready, rsp_valid, rsp_dout
    );
endinterface

// File: rtl/la_spram_ctrl_rspq.sv
// Two-entry response FIFO; push lands at the next edge, head is a plain mux.
// Caller guarantees no push when full and no pop when empty.
module la_spram_ctrl_rspq #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    count,
    output logic [DW-1:0] head
);
    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/la_spram_ctrl.sv
// Front-end for a 1-cycle-latency single-port RAM: optional zero fill after reset, then
// valid/ready requests with read responses buffered two deep; reads see data 2 cycles after accept.
module la_spram_ctrl #(
    parameter int DW    = 32,
    parameter int AW    = 10,
    parameter int CLEAR = 1
) (
    input  logic          clk,
    input  logic          reset,
    la_spram_ctrl_if.slave bus,
    output logic          busy,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wmask,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);
    localparam logic ST_CLR = 1'b0;
    localparam logic ST_RUN = 1'b1;
    localparam logic [AW-1:0] CLR_LAST = {AW{1'b1}};

    typedef enum logic {CLR = ST_CLR, RUN = ST_RUN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] clr_cnt;
    logic          inflight;
    logic          accept;
    logic          pop;
    logic          rsp_vld;
    logic          credit;
    logic [1:0]    count;
    logic [2:0]    occ;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= (CLEAR != 0) ? CLR : RUN;
            clr_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == CLR && clr_cnt != CLR_LAST) clr_cnt <= clr_cnt + 1'b1;
            inflight <= accept && !bus.req_we;
        end
    end

    // Slots already promised = buffered + in flight, less the one leaving this cycle.
    assign occ    = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign credit = (occ < 3'd2);
    assign accept = bus.req_valid && bus.req_ready;

    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        bus.req_ready = 1'b0;
        mem_ce        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = bus.req_addr;
        mem_wmask     = bus.req_wmask;
        mem_din       = bus.req_din;
        if (reset) begin
            busy = (CLEAR != 0);
        end else begin
            case (state)
                CLR: begin
                    busy      = 1'b1;
                    mem_ce    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = clr_cnt;
                    mem_wmask = '1;
                    mem_din   = '0;
                    if (clr_cnt == CLR_LAST) state_nxt = RUN;
                end
                RUN: begin
                    bus.req_ready = credit;
                    mem_ce        = bus.req_valid && credit;
                    mem_we        = bus.req_we;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign rsp_vld       = (count != 2'd0) && !reset;
    assign bus.rsp_valid = rsp_vld;
    assign pop           = rsp_vld && bus.rsp_ready;

    la_spram_ctrl_rspq #(.DW(DW)) u_rspq (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (mem_dout),
        .pop       (pop),
        .count     (count),
        .head      (bus.rsp_dout)
    );
endmodule

// File: doc/la_spram_ctrl.md
LA_SPRAM_CTRL -- requirements
Module: la_spram_ctrl

Interface
REQ-001 Parameter DW, default 32: data width, equal to the la_spram DW.
REQ-002 Parameter AW, default 10: address width, equal to the la_spram AW.
REQ-003 Parameter CLEAR, default 1: 1 = zero-fill the whole memory after reset; 0 = skip the fill.
REQ-004 clk  in  1  single clock for all state.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  request accepted when req_valid and req_ready are both high.
REQ-008 req_we  in  1  1 = write, 0 = read.
REQ-009 req_addr  in  AW  word address.
REQ-010 req_wmask  in  DW  per-bit write mask.
REQ-011 req_din  in  DW  write data.
REQ-012 rsp_valid  out  1  read data present.
REQ-013 rsp_ready  in  1  consumer accepts read data.
REQ-014 rsp_dout  out  DW  read data.
REQ-015 busy  out  1  clear sequence in progress.
REQ-016 mem_ce, mem_we  out  1 each  to la_spram ce/we.
REQ-017 mem_addr  out  AW; mem_wmask, mem_din  out  DW  to la_spram.
REQ-018 mem_dout  in  DW  from la_spram dout (registered, 1-cycle read latency).

Function
REQ-019 FSM SHALL have states CLR and RUN; reset enters CLR if CLEAR=1, else RUN.
REQ-020 CLR: each cycle drive mem_ce=1, mem_we=1, mem_wmask=all ones, mem_din=0, mem_addr=clr_cnt; clr_cnt increments from 0.
REQ-021 CLR SHALL exit to RUN in the cycle after the write to address 2^AW-1 (2^AW fill cycles total); clr_cnt SHALL NOT wrap.
REQ-022 busy=1 exactly while in CLR; req_ready=0 in CLR.
REQ-023 RUN: mem_ce=req_valid&req_ready; mem_we=req_we; mem_addr/mem_wmask/mem_din pass combinationally from req_*; mem_ce=0 when no request is accepted.
REQ-024 Writes SHALL produce no response; reads SHALL produce exactly one response, in request order.
REQ-025 Read accepted in cycle N: capture mem_dout into the response buffer at the clk edge ending cycle N+1; rsp_valid is high from cycle N+2 at the earliest.
REQ-026 Response buffer: 2-entry FIFO; rsp_valid=count!=0; rsp_dout=head entry; pop on rsp_valid&rsp_ready.
REQ-027 inflight flag = a read was accepted in the previous cycle.
REQ-028 req_ready (RUN) = count + inflight - pop < 2; this is the only combinational path from rsp_ready to req_ready.
REQ-029 req_ready SHALL NOT depend on req_we; while the buffer is full, writes stall as reads do.
REQ-030 With rsp_ready held high, back-to-back reads SHALL sustain one accept per cycle.
REQ-031 Simultaneous capture and pop SHALL leave count unchanged; overflow and underflow SHALL be impossible by construction.
REQ-032 rsp_dout SHALL stay stable while rsp_valid=1 and rsp_ready=0.

Reset
REQ-033 Reset values: count=0, inflight=0, clr_cnt=0, rsp_valid=0, req_ready=0, busy=CLEAR, mem_ce=0 in the reset cycle.
REQ-034 Reset asserted mid-operation SHALL discard buffered and in-flight read data and restart the clear sequence from address 0 (CLEAR=1).
REQ-035 FIFO storage data SHALL NOT require reset.

Structure
REQ-036 No shared package; the two state encodings SHALL be local parameters.
REQ-037 The 2-entry response FIFO SHALL be one sub-module, la_spram_ctrl_rspq (parameter DW).
REQ-038 Top level SHALL hold the FSM, clear counter, credit logic and memory-port muxing; la_spram is instantiated by the integrator, not inside this block.

Verification (bench pairs the block with la_spram, DW=8, AW=4)
REQ-039 Clear: release reset, CLEAR=1 -> busy high exactly 16 cycles, mem_addr 0..15; then read all addresses -> every rsp_dout=0x00.
REQ-040 Mask: write addr 3, din=0xFF, wmask=0xFF; then write addr 3, din=0x00, wmask=0x0F; read addr 3 -> rsp_dout=0xF0, rsp_valid 2 cycles after accept.
REQ-041 Throughput: rsp_ready=1, 16 consecutive reads -> 16 accepts in 16 cycles, responses in address order.
REQ-042 Backpressure: rsp_ready=0, issue reads -> exactly 2 accepted, then req_ready=0 with rsp_dout stable; raise rsp_ready -> both responses drain, then reads resume.
REQ-043 Reset mid-burst: assert reset with 2 responses buffered -> rsp_valid=0 next cycle, busy=1, clear restarts at addr 0, no stale response ever appears.
REQ-044 CLEAR=0: release reset -> busy=0 and req_ready=1 in the first cycle after reset.
